// File: rtl/shift_arbiter.sv
// shift_arbiter: grants one of REQ_COUNT valid/ready requesters at a time to a shared shifter.
// The default build uses round-robin; defining SHIFT_ARB_FIXED_PRIO_EN makes the lowest index always win.
module shift_arbiter #(
  parameter int WORD_WIDTH = 8,
  parameter int REQ_COUNT  = 4,
  parameter int SIZE_WIDTH = $clog2(WORD_WIDTH),
  parameter int ID_WIDTH   = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [REQ_COUNT-1:0]             req_valid_i,
  output logic [REQ_COUNT-1:0]             req_ready_o,
  input  logic [REQ_COUNT*WORD_WIDTH-1:0]  req_word_i,
  input  logic [REQ_COUNT*SIZE_WIDTH-1:0]  req_size_i,
  input  logic [REQ_COUNT*2-1:0]           req_type_i,
  input  logic [REQ_COUNT-1:0]             req_left_i,
  output logic [WORD_WIDTH-1:0]            sh_word_o,
  output logic [SIZE_WIDTH-1:0]            sh_size_o,
  output logic [1:0]                       sh_type_o,
  output logic                             sh_left_o,
  input  logic [WORD_WIDTH-1:0]            sh_result_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic [WORD_WIDTH-1:0]            rsp_word_o,
  output logic [ID_WIDTH-1:0]              rsp_id_o
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] op_word;
  logic [SIZE_WIDTH-1:0] op_size;
  logic [1:0]            op_type;
  logic                  op_left;
  logic [ID_WIDTH-1:0]   op_id;
  logic [WORD_WIDTH-1:0] rsp_word;
  logic                  rsp_valid;
  logic [ID_WIDTH-1:0]   rr_ptr;

  logic [REQ_COUNT-1:0]  win_onehot;
  logic [ID_WIDTH-1:0]   win_id;
  logic [WORD_WIDTH-1:0] win_word;
  logic [SIZE_WIDTH-1:0] win_size;
  logic [1:0]            win_type;
  logic                  win_left;
  logic                  any_valid;

`ifdef SHIFT_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`endif

  assign any_valid = |req_valid_i;

  // Pass 1 overrides pass 0 and each pass writes the lowest index last, so the winner is the
  // first valid index at or above rr_ptr, falling back to the first valid index below it.
  always_comb begin
    win_onehot = '0;
    win_id     = '0;
    win_word   = '0;
    win_size   = '0;
    win_type   = '0;
    win_left   = 1'b0;
    for (int unsigned p = 0; p < 2; p++) begin
      for (int unsigned j = REQ_COUNT; j > 0; j--) begin
        if (req_valid_i[j-1] && ((p == 1) == ((j - 1) >= 32'(rr_ptr)))) begin
          win_onehot        = '0;
          win_onehot[j-1]   = 1'b1;
          win_id            = ID_WIDTH'(j - 1);
          win_word          = req_word_i[(j-1)*WORD_WIDTH +: WORD_WIDTH];
          win_size          = req_size_i[(j-1)*SIZE_WIDTH +: SIZE_WIDTH];
          win_type          = req_type_i[(j-1)*2 +: 2];
          win_left          = req_left_i[j-1];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      op_word   <= '0;
      op_size   <= '0;
      op_type   <= '0;
      op_left   <= 1'b0;
      op_id     <= '0;
      rsp_word  <= '0;
      rsp_valid <= 1'b0;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
      rr_ptr    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            op_word <= win_word;
            op_size <= win_size;
            op_type <= win_type;
            op_left <= win_left;
            op_id   <= win_id;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_word  <= sh_result_i;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid <= 1'b0;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
            rr_ptr    <= (op_id == ID_WIDTH'(REQ_COUNT - 1)) ? '0 : op_id + 1'b1;
`endif
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is asserted, before the synchronous reset has taken effect.
  assign req_ready_o = (rst_ni && state == IDLE) ? win_onehot : '0;
  assign sh_word_o   = rst_ni ? op_word  : '0;
  assign sh_size_o   = rst_ni ? op_size  : '0;
  assign sh_type_o   = rst_ni ? op_type  : '0;
  assign sh_left_o   = rst_ni & op_left;
  assign rsp_valid_o = rst_ni & rsp_valid;
  assign rsp_word_o  = rst_ni ? rsp_word : '0;
  assign rsp_id_o    = rst_ni ? op_id    : '0;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: randomized self-checking bench for shift_arbiter with a behavioural shifter.
// Expected grants and results come from a modular-search arbiter model and arithmetic shifts.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_word;
  logic [11:0] req_size;
  logic [7:0]  req_type;
  logic [3:0]  req_left;
  logic [7:0]  sh_word;
  logic [2:0]  sh_size;
  logic [1:0]  sh_type;
  logic        sh_left;
  logic [7:0]  sh_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_word;
  logic [1:0]  rsp_id;

  logic [7:0]  op_w [4];
  logic [2:0]  op_s [4];
  logic        op_l [4];
  logic [1:0]  op_t [4];

  int total = 0;
  int bad   = 0;
  int exp_ptr;

  int          e_id;
  logic [3:0]  e_rdy;
  logic [7:0]  e_w, e_res;
  logic [2:0]  e_s;
  logic        e_l;
  logic [1:0]  e_t;

  logic [3:0]  cap_rdy, cap_rdy_exec, cap_rdy_resp;
  logic [7:0]  cap_w, cap_rw;
  logic [2:0]  cap_s;
  logic        cap_l, cap_rv, cap_rv_exec;
  logic [1:0]  cap_t, cap_rid;

  always #5 clk = ~clk;

  shift_arbiter #(.WORD_WIDTH(8), .REQ_COUNT(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_word_i  (req_word),
    .req_size_i  (req_size),
    .req_type_i  (req_type),
    .req_left_i  (req_left),
    .sh_word_o   (sh_word),
    .sh_size_o   (sh_size),
    .sh_type_o   (sh_type),
    .sh_left_o   (sh_left),
    .sh_result_i (sh_result),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_word_o  (rsp_word),
    .rsp_id_o    (rsp_id)
  );

  assign sh_result = sh_left ? (sh_word << sh_size) : (sh_word >> sh_size);

  always_comb begin
    req_word = '0;
    req_size = '0;
    req_type = '0;
    req_left = '0;
    for (int k = 0; k < 4; k++) begin
      req_word[k*8 +: 8] = op_w[k];
      req_size[k*3 +: 3] = op_s[k];
      req_type[k*2 +: 2] = op_t[k];
      req_left[k]        = op_l[k];
    end
  end

  function automatic int model_winner(logic [3:0] v, int ptr);
    for (int d = 0; d < 4; d++)
      if (v[(ptr + d) % 4]) return (ptr + d) % 4;
    return -1;
  endfunction

  function automatic logic [7:0] model_shift(logic [7:0] w, logic [2:0] s, logic left);
    int p;
    p = 1 << s;
    if (left) return 8'((int'(w) * p) % 256);
    return 8'(int'(w) / p);
  endfunction

  task automatic randomize_ops();
    for (int k = 0; k < 4; k++) begin
      op_w[k] = 8'($urandom);
      op_s[k] = 3'($urandom);
      op_l[k] = 1'($urandom);
      op_t[k] = 2'($urandom);
    end
  endtask

  task automatic predict();
    e_id = model_winner(req_valid, exp_ptr);
    if (e_id < 0) e_id = 0;
    e_rdy = 4'(1 << e_id);
    e_w   = op_w[e_id];
    e_s   = op_s[e_id];
    e_l   = op_l[e_id];
    e_t   = op_t[e_id];
    e_res = model_shift(e_w, e_s, e_l);
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    exp_ptr = 0;
`else
    exp_ptr = (e_id + 1) % 4;
`endif
  endtask

  // Observes one IDLE->EXEC->RESP->IDLE pass with rsp_ready high; starts and ends 1 unit after posedge.
  task automatic run_txn(input logic [3:0] valid_after);
    @(negedge clk);
    cap_rdy = req_ready;
    @(posedge clk);
    #1;
    req_valid = valid_after;
    randomize_ops();
    @(negedge clk);
    cap_w        = sh_word;
    cap_s        = sh_size;
    cap_l        = sh_left;
    cap_t        = sh_type;
    cap_rdy_exec = req_ready;
    cap_rv_exec  = rsp_valid;
    @(negedge clk);
    cap_rv       = rsp_valid;
    cap_rw       = rsp_word;
    cap_rid      = rsp_id;
    cap_rdy_resp = req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    randomize_ops();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL reset_ready: got %h want 0", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    total++; if (sh_word !== 8'h00) begin bad++; $display("FAIL reset_sh_word: got %h want 00", sh_word); end
    total++; if (sh_size !== 3'd0 || sh_left !== 1'b0 || sh_type !== 2'd0) begin
      bad++; $display("FAIL reset_sh_ctrl: got size=%0d left=%b type=%0d want 0", sh_size, sh_left, sh_type);
    end
    total++; if (rsp_word !== 8'h00 || rsp_id !== 2'd0) begin
      bad++; $display("FAIL reset_rsp: got word=%h id=%0d want 0", rsp_word, rsp_id);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = 4'h0;
    exp_ptr = 0;
    @(negedge clk);
    total++; if (req_ready !== 4'h0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset: got ready=%h rsp_valid=%b want 0", req_ready, rsp_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    req_valid = 4'b0010;
    op_w[1] = 8'hA5; op_s[1] = 3'd3; op_l[1] = 1'b1; op_t[1] = 2'b00;
    predict();
    run_txn(4'b0000);
    total++; if (cap_rdy !== 4'b0010) begin bad++; $display("FAIL single_ready: got %b want 0010", cap_rdy); end
    total++; if (cap_w !== 8'hA5) begin bad++; $display("FAIL single_sh_word: got %h want a5", cap_w); end
    total++; if (cap_s !== 3'd3 || cap_l !== 1'b1 || cap_t !== 2'b00) begin
      bad++; $display("FAIL single_sh_ctrl: got size=%0d left=%b type=%0d want 3 1 0", cap_s, cap_l, cap_t);
    end
    total++; if (cap_rdy_exec !== 4'h0 || cap_rv_exec !== 1'b0) begin
      bad++; $display("FAIL single_exec: got ready=%h rsp_valid=%b want 0 0", cap_rdy_exec, cap_rv_exec);
    end
    total++; if (cap_rv !== 1'b1) begin bad++; $display("FAIL single_rsp_valid: got %b want 1", cap_rv); end
    total++; if (cap_rw !== 8'h28) begin bad++; $display("FAIL single_rsp_word: got %h want 28", cap_rw); end
    total++; if (cap_rid !== 2'd1) begin bad++; $display("FAIL single_rsp_id: got %0d want 1", cap_rid); end
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_ptr = 0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      randomize_ops();
      predict();
      run_txn(4'hF);
      total++; if (cap_rdy !== e_rdy || !$onehot(cap_rdy)) begin
        bad++; $display("FAIL rr_ready[%0d]: got %b want %b", n, cap_rdy, e_rdy);
      end
      total++; if (cap_rid !== 2'(e_id) || cap_rv !== 1'b1) begin
        bad++; $display("FAIL rr_id[%0d]: got id=%0d valid=%b want %0d 1", n, cap_rid, cap_rv, e_id);
      end
      total++; if (cap_w !== e_w || cap_rw !== e_res) begin
        bad++; $display("FAIL rr_data[%0d]: got op=%h res=%h want %h %h", n, cap_w, cap_rw, e_w, e_res);
      end
    end
  endtask

  task automatic test_backpressure();
    int nxt;
    req_valid = 4'(1 << $urandom_range(0, 3));
    randomize_ops();
    predict();
    rsp_ready = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== e_rdy) begin bad++; $display("FAIL bp_ready: got %b want %b", req_ready, e_rdy); end
    @(posedge clk);
    #1;
    req_valid = 4'hF;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      randomize_ops();
      total++; if (rsp_valid !== 1'b1 || rsp_word !== e_res || rsp_id !== 2'(e_id)) begin
        bad++; $display("FAIL bp_hold[%0d]: got v=%b w=%h id=%0d want 1 %h %0d", c, rsp_valid, rsp_word, rsp_id, e_res, e_id);
      end
      total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL bp_ready_low[%0d]: got %b want 0000", c, req_ready); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    nxt = model_winner(4'hF, exp_ptr);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got rsp_valid=%b want 0", rsp_valid); end
    total++; if (req_ready !== 4'(1 << nxt)) begin bad++; $display("FAIL bp_next_ready: got %b want %b", req_ready, 4'(1 << nxt)); end
    req_valid = 4'h0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_pointer_wrap();
    logic [3:0] pat [4];
    pat = '{4'b1000, 4'b0101, 4'b0100, 4'b0000};
    rsp_ready = 1'b1;
    req_valid = pat[0];
    for (int i = 0; i < 3; i++) begin
      randomize_ops();
      predict();
      run_txn(pat[i+1]);
      total++; if (cap_rdy !== e_rdy) begin bad++; $display("FAIL wrap_ready[%0d]: got %b want %b", i, cap_rdy, e_rdy); end
      total++; if (cap_rid !== 2'(e_id) || cap_rw !== e_res) begin
        bad++; $display("FAIL wrap_rsp[%0d]: got id=%0d w=%h want %0d %h", i, cap_rid, cap_rw, e_id, e_res);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    randomize_ops();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 4'h0 || rsp_valid !== 1'b0 || sh_word !== 8'h00) begin
      bad++; $display("FAIL midrst_outputs: got ready=%h v=%b sh=%h want 0", req_ready, rsp_valid, sh_word);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = 4'h0;
    exp_ptr = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_rsp[%0d]: got %b want 0", c, rsp_valid); end
      @(posedge clk);
      #1;
    end
    req_valid = 4'hF;
    randomize_ops();
    predict();
    run_txn(4'h0);
    total++; if (cap_rdy !== 4'b0001 || cap_rid !== 2'd0) begin
      bad++; $display("FAIL midrst_first_grant: got ready=%b id=%0d want 0001 0", cap_rdy, cap_rid);
    end
    total++; if (cap_rw !== e_res) begin bad++; $display("FAIL midrst_rsp_word: got %h want %h", cap_rw, e_res); end
  endtask

  task automatic test_random();
    rsp_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      req_valid = 4'($urandom_range(1, 15));
      randomize_ops();
      predict();
      run_txn(4'($urandom));
      total++; if (cap_rdy !== e_rdy) begin bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, cap_rdy, e_rdy); end
      total++; if (cap_w !== e_w || cap_s !== e_s || cap_l !== e_l || cap_t !== e_t) begin
        bad++; $display("FAIL rnd_operands[%0d]: got %h/%0d/%b/%0d want %h/%0d/%b/%0d", n, cap_w, cap_s, cap_l, cap_t, e_w, e_s, e_l, e_t);
      end
      total++; if (cap_rv !== 1'b1 || cap_rw !== e_res || cap_rid !== 2'(e_id)) begin
        bad++; $display("FAIL rnd_rsp[%0d]: got v=%b w=%h id=%0d want 1 %h %0d", n, cap_rv, cap_rw, cap_rid, e_res, e_id);
      end
      total++; if (cap_rdy_exec !== 4'h0 || cap_rdy_resp !== 4'h0) begin
        bad++; $display("FAIL rnd_busy_ready[%0d]: got exec=%b resp=%b want 0000", n, cap_rdy_exec, cap_rdy_resp);
      end
    end
  endtask

`ifdef SHIFT_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    rsp_ready = 1'b1;
    req_valid = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      randomize_ops();
      predict();
      run_txn((i == 2) ? 4'b0100 : 4'b0101);
      total++; if (cap_rid !== 2'(e_id) || cap_rdy !== e_rdy) begin
        bad++; $display("FAIL fixed_grant[%0d]: got id=%0d ready=%b want %0d %b", i, cap_rid, cap_rdy, e_id, e_rdy);
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_pointer_wrap();
    test_reset_mid_op();
    test_random();
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
